rf_writeback_arb: RTL and testbench

- Writer-side front end for the 32x32 integer register file: the only block that drives its write port (wen/waddr/wdata).
- Merges retiring results from two producers: the single-cycle ALU path, buffered in a small FIFO, and the variable-latency LSU path.
- Keeps a scoreboard of destination registers with loads in flight, so decode can stall on read-after-write hazards.
- Sits between execute/LSU and the register file in npc.

---
 rtl/npc_pkg.sv | 14 +
 rtl/wb_sync_fifo.sv | 56 +++++
 rtl/rf_writeback_arb.sv | 115 +++++++++++
 tb/tb_rf_writeback_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared npc types for the register-file writeback path: register addressing
// constants and the request record carried by the ALU result FIFO.
package npc_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO of wb_req_t records with a combinational head view.
// A push while full is refused even if a pop happens in the same cycle.
module wb_sync_fifo
  import npc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_req_t          mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign head    = mem_reg[rd_ptr_reg];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/rf_writeback_arb.sv
// Register-file write-port arbiter: merges buffered ALU results with LSU load
// data and tracks in-flight load destinations. Define WB_PERF_CNT_EN for perf counters.
module rf_writeback_arb #(
  parameter int ALU_FIFO_DEPTH = 4,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            lsu_issue,
  input  logic [4:0]      lsu_issue_rd,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy_mask
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]     perf_wr_cnt,
  output logic [31:0]     perf_lsu_stall_cnt,
  output logic [31:0]     perf_alu_stall_cnt
`endif
);

  import npc_pkg::*;

  wb_req_t                 alu_req;
  wb_req_t                 head_req;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    lsu_win;
  logic                    fifo_win;
  logic                    wr_next;
  logic [REG_ADDR_W-1:0]   win_rd;
  logic [XLEN-1:0]         win_data;
  logic [NUM_REGS-1:0]     busy_next;

  assign alu_req.rd   = alu_rd;
  assign alu_req.data = alu_data;

  wb_sync_fifo #(
    .DEPTH(ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (alu_valid),
    .push_data(alu_req),
    .pop      (fifo_win),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_req)
  );

  // A full FIFO takes priority so ALU back-pressure can always drain.
  assign alu_ready = !fifo_full;
  assign lsu_ready = !fifo_full;
  assign lsu_win   = lsu_valid && !fifo_full;
  assign fifo_win  = !lsu_win && !fifo_empty;

  assign win_rd   = lsu_win ? lsu_rd   : head_req.rd;
  assign win_data = lsu_win ? lsu_data : head_req.data;
  assign wr_next  = (lsu_win || fifo_win) && (win_rd != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_next[gi] = 1'b0;
      end else begin : g_xn
        logic set_hit;
        logic clr_hit;
        assign set_hit       = lsu_issue && (lsu_issue_rd == REG_ADDR_W'(gi));
        assign clr_hit       = lsu_win && (lsu_rd == REG_ADDR_W'(gi));
        assign busy_next[gi] = set_hit || (busy_mask[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      busy_mask <= '0;
    end else begin
      rf_wen    <= wr_next;
      busy_mask <= busy_next;
      if (wr_next) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_wr_cnt        <= '0;
      perf_lsu_stall_cnt <= '0;
      perf_alu_stall_cnt <= '0;
    end else begin
      if (rf_wen)                  perf_wr_cnt        <= perf_wr_cnt + 32'd1;
      if (lsu_valid && !lsu_ready) perf_lsu_stall_cnt <= perf_lsu_stall_cnt + 32'd1;
      if (alu_valid && !alu_ready) perf_alu_stall_cnt <= perf_alu_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_writeback_arb.sv
// Bench for rf_writeback_arb: directed vector table, a full-FIFO sequence and
// randomized traffic against a queue-based reference model.
module tb_rf_writeback_arb;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_issue;
  logic [4:0]  lsu_issue_rd;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_wr_cnt;
  logic [31:0] perf_lsu_stall_cnt;
  logic [31:0] perf_alu_stall_cnt;
`endif

  always #5 clk = ~clk;

  rf_writeback_arb #(
    .ALU_FIFO_DEPTH(DEPTH),
    .XLEN          (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_issue   (lsu_issue),
    .lsu_issue_rd(lsu_issue_rd),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy_mask   (busy_mask)
`ifdef WB_PERF_CNT_EN
    ,
    .perf_wr_cnt       (perf_wr_cnt),
    .perf_lsu_stall_cnt(perf_lsu_stall_cnt),
    .perf_alu_stall_cnt(perf_alu_stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic iss, input logic [4:0] ird);
    rst_n = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    lsu_issue = iss; lsu_issue_rd = ird;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iss;
    logic [4:0]  ird;
    logic        e_rdy;
    logic        e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic iss, input logic [4:0] ird,
                              input logic e_rdy, input logic e_wen, input logic [4:0] e_waddr,
                              input logic [31:0] e_wdata, input logic [31:0] e_busy);
    vec_t v;
    v.r = r; v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iss = iss; v.ird = ird; v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_waddr = e_waddr;
    v.e_wdata = e_wdata; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic apply_vec(input int idx, input vec_t v);
    set_in(v.r, v.av, v.ard, v.ad, v.lv, v.lrd, v.ld, v.iss, v.ird);
    #1;
    chk($sformatf("vec%0d alu_ready", idx), 32'(alu_ready), 32'(v.e_rdy));
    chk($sformatf("vec%0d lsu_ready", idx), 32'(lsu_ready), 32'(v.e_rdy));
    @(posedge clk); #1;
    chk($sformatf("vec%0d rf_wen", idx), 32'(rf_wen), 32'(v.e_wen));
    if (v.e_wen) begin
      chk($sformatf("vec%0d rf_waddr", idx), 32'(rf_waddr), 32'(v.e_waddr));
      chk($sformatf("vec%0d rf_wdata", idx), rf_wdata, v.e_wdata);
    end
    chk($sformatf("vec%0d busy_mask", idx), busy_mask, v.e_busy);
    $display("vec %0d: rf_wen=%0b waddr=%0d wdata=0x%08h busy=0x%08h", idx, rf_wen, rf_waddr, rf_wdata, busy_mask);
  endtask

  // ---------------- reference model ----------------
  logic [4:0]  q_rd[$];
  logic [31:0] q_data[$];
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_busy;

  task automatic run_cycle(input string tag, input bit verbose);
    bit          full;
    bit          have;
    logic [4:0]  wrd;
    logic [31:0] wd;
    #1;
    full = (q_rd.size() == DEPTH);
    chk({tag, " alu_ready"}, 32'(alu_ready), 32'(!full));
    chk({tag, " lsu_ready"}, 32'(lsu_ready), 32'(!full));
    if (!rst_n) begin
      q_rd.delete(); q_data.delete();
      m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0;
    end else begin
      have = 1'b0; wrd = '0; wd = '0;
      if (lsu_valid && !full) begin
        have = 1'b1; wrd = lsu_rd; wd = lsu_data;
        m_busy[lsu_rd] = 1'b0;
      end else if (q_rd.size() != 0) begin
        have = 1'b1; wrd = q_rd.pop_front(); wd = q_data.pop_front();
      end
      if (alu_valid && !full) begin
        q_rd.push_back(alu_rd); q_data.push_back(alu_data);
      end
      if (lsu_issue && lsu_issue_rd != '0) m_busy[lsu_issue_rd] = 1'b1;
      m_wen = have && (wrd != '0);
      if (m_wen) begin
        m_waddr = wrd; m_wdata = wd;
      end
    end
    @(posedge clk); #1;
    chk({tag, " rf_wen"},    32'(rf_wen),   32'(m_wen));
    chk({tag, " rf_waddr"},  32'(rf_waddr), 32'(m_waddr));
    chk({tag, " rf_wdata"},  rf_wdata,      m_wdata);
    chk({tag, " busy_mask"}, busy_mask,     m_busy);
    if (verbose || m_wen)
      $display("%s: rf_wen=%0b x%0d=0x%08h busy=0x%08h", tag, m_wen, m_waddr, m_wdata, m_busy);
  endtask

  initial begin
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1;

    //          r  av ard    ad            lv lrd    ld            iss ird   rdy wen addr   wdata         busy
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 5'd5,  32'h11,       0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 1, 5'd5,  32'h11,       32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 5'd3,  32'hA,        0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        1, 5'd7,  32'hB,        0, 5'd0, 1, 1, 5'd7,  32'hB,        32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 1, 5'd3,  32'hA,        32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 5'd0,  32'hDEAD,     0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 5'd1,  32'h1,        0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 1, 5'd1,  32'h1,        32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd9, 1, 0, 5'd0,  32'h0,        32'h200));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        1, 5'd9,  32'h99,       1, 5'd9, 1, 1, 5'd9,  32'h99,       32'h200));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        1, 5'd9,  32'h77,       0, 5'd0, 1, 1, 5'd9,  32'h77,       32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd9, 1, 0, 5'd0,  32'h0,        32'h200));
    tbl.push_back(mk(1, 1, 5'd10, 32'hA0,       1, 5'd20, 32'h20,       0, 5'd0, 1, 1, 5'd20, 32'h20,       32'h200));
    tbl.push_back(mk(1, 1, 5'd11, 32'hA1,       1, 5'd21, 32'h21,       0, 5'd0, 1, 1, 5'd21, 32'h21,       32'h200));
    tbl.push_back(mk(1, 1, 5'd12, 32'hA2,       1, 5'd22, 32'h22,       0, 5'd0, 1, 1, 5'd22, 32'h22,       32'h200));
    // Reset with three queued ALU results and x9 busy: none of them may ever be written.
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 5'd0,  32'h0,        32'h0));

    for (int i = 0; i < tbl.size(); i++) apply_vec(i, tbl[i]);

    // Full FIFO: four ALU pushes while the LSU keeps winning, then back-pressure.
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    run_cycle("full rst", 1'b1);
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 1'b1, 5'(k + 1), 32'h100 + 32'(k), 1'b1, 5'd15, 32'hF0 + 32'(k), 1'b0, 5'd0);
      run_cycle($sformatf("full push%0d", k), 1'b1);
    end
    set_in(1'b1, 1'b1, 5'd5, 32'h104, 1'b1, 5'd15, 32'hF4, 1'b0, 5'd0);
    #1;
    chk("full alu_ready low", 32'(alu_ready), 32'd0);
    chk("full lsu_ready low", 32'(lsu_ready), 32'd0);
    run_cycle("full drain0", 1'b1);
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 32'hF5, 1'b0, 5'd0);
    run_cycle("full lsu_after", 1'b1);
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    for (int k = 0; k < 6; k++) run_cycle($sformatf("full drain%0d", k + 1), 1'b1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      set_in(1'($urandom_range(0, 99) != 0),
             1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
             1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom,
             1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 31)));
      run_cycle($sformatf("rnd%0d", n), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
